// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master: transfer phases and the buffered
// command record.
package apb_master_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from the registered occupancy
// count, so a same-cycle pop never frees a slot early and nothing falls through.
module apb_cmd_fifo
    import apb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  apb_cmd_t din,
    input  logic     pop,
    output apb_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    apb_cmd_t           mem_q [DEPTH];
    apb_cmd_t           mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: drains buffered commands one transfer at a time, aborts
// stalled ACCESS phases after TIMEOUT cycles, and holds one response.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_err_q, rsp_err_d;

    apb_cmd_t fifo_din;
    apb_cmd_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;
    logic     slot_free;

    assign fifo_din = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    apb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (cmd_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response being drained this cycle frees the slot for the next transfer.
    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop  = 1'b1;
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = fifo_head.write;
                    paddr_d   = fifo_head.addr;
                    pwdata_d  = fifo_head.wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready || (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_err_d   = !pready;
                    rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: acts as the APB completer with a byte memory and
// predicts every response from command order, wait counts and the timeout rule.
module tb_apb_cmd_master;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_write;
    logic       rsp_err;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;

    always #5 pclk = ~pclk;

    apb_cmd_master #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    typedef struct {
        logic       write;
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    int          total = 0;
    int          bad = 0;
    rsp_t        exp_q[$];
    int          wait_q[$];
    logic [16:0] cmd_q[$];
    logic [7:0]  model_mem [256];
    logic [7:0]  dev_mem [256];
    int          n_push = 0;
    int          n_setup = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Completer: one wait count per transfer, pready on ACCESS cycle wait+1.
    logic [16:0] cur_cmd = '0;
    int          cur_wait = 0;
    int          acc_n = 0;
    logic        prev_acc = 1'b0;

    always @(negedge pclk) begin
        if (preset) begin
            acc_n    = 0;
            prev_acc = 1'b0;
            pready   = 1'b0;
        end else begin
            pready = 1'b0;
            prdata = 8'($urandom);
            chk("penable_implies_psel", {31'd0, penable & ~psel}, 0);
            if (psel && !penable) begin
                chk("idle_between_transfers", {31'd0, prev_acc}, 0);
                chk("setup_expected", {31'd0, cmd_q.size() > 0 && wait_q.size() > 0}, 1);
                if (cmd_q.size() > 0 && wait_q.size() > 0) begin
                    cur_cmd  = cmd_q.pop_front();
                    cur_wait = wait_q.pop_front();
                end
                chk("setup_cmd", {pwrite, paddr, pwdata}, cur_cmd);
                acc_n = 0;
            end
            if (psel && penable) begin
                acc_n++;
                chk("access_stable", {pwrite, paddr, pwdata}, cur_cmd);
                chk("access_len_bound", {31'd0, acc_n <= TO}, 1);
                if (acc_n == cur_wait + 1) begin
                    pready = 1'b1;
                    if (pwrite) dev_mem[paddr] = pwdata;
                    else        prdata = dev_mem[paddr];
                end
            end
            prev_acc = psel && penable;
        end
    end

    task automatic step(input logic v, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input int wt, input logic rr,
                        output logic acc);
        rsp_t e;
        @(negedge pclk);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = rr;
        if (psel && !penable) n_setup++;
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (n_push - n_setup) < DEPTH});
        acc = v && cmd_ready;
        if (acc) begin
            n_push++;
            cmd_q.push_back({w, a, d});
            wait_q.push_back(wt);
            e.write = w;
            if (wt >= TO) begin
                e.err   = 1'b1;
                e.rdata = 8'h00;
            end else begin
                e.err   = 1'b0;
                if (w) begin
                    model_mem[a] = d;
                    e.rdata      = 8'h00;
                end else begin
                    e.rdata = model_mem[a];
                end
            end
            exp_q.push_back(e);
        end
        if (rsp_valid && rr) begin
            chk("rsp_pending", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_write", {31'd0, rsp_write}, {31'd0, e.write});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            end
        end
    endtask

    task automatic idle(input logic rr);
        logic x;
        step(1'b0, 1'b0, 8'h00, 8'h00, 0, rr, x);
    endtask

    initial begin
        logic       acc, got;
        int         n_acc, pushed, setup0, wt, r;
        logic       cw;
        logic [7:0] ca, cd;

        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            dev_mem[i]   = 8'h00;
        end

        // Reset values
        #12;
        chk("rst_psel", {31'd0, psel}, 0);
        chk("rst_penable", {31'd0, penable}, 0);
        chk("rst_pwrite", {31'd0, pwrite}, 0);
        chk("rst_paddr", {24'd0, paddr}, 0);
        chk("rst_pwdata", {24'd0, pwdata}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 0);
        chk("rst_rsp_write", {31'd0, rsp_write}, 0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        @(negedge pclk);
        preset = 1'b0;

        // Write 0x01 to 0x00 then read it back, checking the phase sequence
        for (int k = 0; k < 2; k++) begin
            step(1'b1, (k == 0), 8'h00, 8'h01, 0, 1'b1, acc);
            idle(1'b1);
            chk("lat_e0_psel", {30'd0, psel, penable}, 2'b00);
            idle(1'b1);
            chk("lat_setup", {30'd0, psel, penable}, 2'b10);
            idle(1'b1);
            chk("lat_access", {30'd0, psel, penable}, 2'b11);
            idle(1'b1);
            chk("lat_done_apb", {30'd0, psel, penable}, 2'b00);
            chk("lat_rsp_valid", {31'd0, rsp_valid}, 1);
            if (k == 1) chk("readback_data", {24'd0, rsp_rdata}, 32'h01);
        end

        // Completer never ready: exactly TO ACCESS cycles, then an error response
        step(1'b1, 1'b0, 8'h10, 8'h00, 100, 1'b1, acc);
        n_acc = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            idle(1'b1);
            if (psel && penable) n_acc++;
            if (rsp_valid) begin
                got = 1'b1;
                chk("timeout_err", {31'd0, rsp_err}, 1);
                chk("timeout_rdata", {24'd0, rsp_rdata}, 0);
            end
        end
        chk("timeout_seen", {31'd0, got}, 1);
        chk("timeout_len", n_acc, TO);

        // pready on the last allowed ACCESS cycle is still a success
        step(1'b1, 1'b0, 8'h00, 8'h00, TO - 1, 1'b1, acc);
        n_acc = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            idle(1'b1);
            if (psel && penable) n_acc++;
            if (rsp_valid) begin
                got = 1'b1;
                chk("late_err", {31'd0, rsp_err}, 0);
                chk("late_rdata", {24'd0, rsp_rdata}, 32'h01);
            end
        end
        chk("late_seen", {31'd0, got}, 1);
        chk("late_len", n_acc, TO);

        // Backpressure: response held, FIFO fills, no further SETUP
        setup0 = n_setup;
        pushed = 0;
        cw = 1'b1; ca = 8'($urandom_range(0, 7)); cd = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            step((pushed < 7), cw, ca, cd, 0, 1'b0, acc);
            if (acc) begin
                pushed++;
                cw = 1'($urandom_range(0, 1));
                ca = 8'($urandom_range(0, 7));
                cd = 8'($urandom);
            end
        end
        chk("bp_accepted", pushed, 5);
        chk("bp_cmd_ready_low", {31'd0, cmd_ready}, 0);
        chk("bp_rsp_held", {31'd0, rsp_valid}, 1);
        chk("bp_single_setup", n_setup - setup0, 1);
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("bp_no_setup_stalled", n_setup - setup0, 1);
        chk("bp_apb_idle", {30'd0, psel, penable}, 0);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1'b1);
        chk("bp_drained", exp_q.size(), 0);

        // Reset in the middle of an ACCESS phase
        step(1'b1, 1'b0, 8'h20, 8'h00, 100, 1'b1, acc);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            idle(1'b1);
            if (psel && penable) got = 1'b1;
        end
        chk("mid_access_reached", {31'd0, got}, 1);
        #2;
        preset = 1'b1;
        #1;
        chk("arst_psel", {31'd0, psel}, 0);
        chk("arst_penable", {31'd0, penable}, 0);
        chk("arst_paddr", {24'd0, paddr}, 0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 0);
        exp_q.delete();
        wait_q.delete();
        cmd_q.delete();
        n_push  = 0;
        n_setup = 0;
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      wt = 0;
            else if (r < 85) wt = $urandom_range(1, 4);
            else if (r < 92) wt = TO - 1;
            else             wt = TO + $urandom_range(0, 3);
            step(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 7)), 8'($urandom), wt,
                 ($urandom_range(0, 9) < 7), acc);
        end
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) idle(1'b1);
        chk("final_drain", exp_q.size(), 0);
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
